// File: rtl/sata_phy_align_scheduler_pkg.sv
// Shared constants, dword payload type and ALIGN detection for the post-OOB PHY conditioner.
package sata_phy_align_scheduler_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;

    // ALIGN primitive: K28.5 D10.2 D10.2 D27.3, K flag on byte 0 only
    localparam logic [DW-1:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [KW-1:0] ALIGN_K    = 4'b0001;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] is_k;
    } sata_dword_t;

    function automatic logic is_align_dw(input logic [DW-1:0] d, input logic [KW-1:0] k);
        return k[0] && (d == PRIM_ALIGN);
    endfunction

endpackage

// File: rtl/sata_phy_align_scheduler_if.sv
// Link-layer facing TX/RX bus of the PHY conditioner.
interface sata_phy_align_scheduler_if;
    import sata_phy_align_scheduler_pkg::*;

    logic [DW-1:0] link_tx_dout;
    logic [KW-1:0] link_tx_is_k;
    logic          phy_ready;
    logic [DW-1:0] rx_dout;
    logic [KW-1:0] rx_is_k_out;
    logic          rx_valid;
    logic          rx_align_seen;

    // Link layer side
    modport master (
        output link_tx_dout, link_tx_is_k,
        input  phy_ready, rx_dout, rx_is_k_out, rx_valid, rx_align_seen
    );

    // PHY conditioner side
    modport slave (
        input  link_tx_dout, link_tx_is_k,
        output phy_ready, rx_dout, rx_is_k_out, rx_valid, rx_align_seen
    );

endinterface

// File: rtl/sata_rx_align_strip.sv
// Registered RX path: forwards received dwords and flags ALIGNs so the link layer can skip them.
module sata_rx_align_strip
    import sata_phy_align_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          linkup,
    input  logic [DW-1:0] rx_din,
    input  logic [KW-1:0] rx_is_k,
    input  logic          phy_error,
    output logic [DW-1:0] rx_dout,
    output logic [KW-1:0] rx_is_k_out,
    output logic          rx_valid,
    output logic          rx_align_seen
);

    logic is_align_c;

    assign is_align_c = is_align_dw(rx_din, rx_is_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dout       <= '0;
            rx_is_k_out   <= '0;
            rx_valid      <= 1'b0;
            rx_align_seen <= 1'b0;
        end else begin
            rx_dout       <= rx_din;
            rx_is_k_out   <= rx_is_k;
            rx_valid      <= linkup && !is_align_c && !phy_error;
            rx_align_seen <= linkup && is_align_c;
        end
    end

endmodule

// File: rtl/sata_phy_align_scheduler.sv
// Post-OOB PHY conditioner: TX source mux with periodic ALIGN bursts, RX ALIGN stripping,
// and windowed phy_error monitoring that latches a sticky platform_error.
module sata_phy_align_scheduler
    import sata_phy_align_scheduler_pkg::*;
#(
    parameter int unsigned ALIGN_PERIOD  = 256,
    parameter int unsigned ALIGN_BURST   = 2,
    parameter int unsigned ERR_WINDOW    = 1024,
    parameter int unsigned ERR_THRESHOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          linkup,
    input  logic [DW-1:0] oob_tx_dout,
    input  logic [KW-1:0] oob_tx_is_k,
    output logic [DW-1:0] tx_dout,
    output logic [KW-1:0] tx_is_k,
    input  logic [DW-1:0] rx_din,
    input  logic [KW-1:0] rx_is_k,
    input  logic          phy_error,
    output logic          platform_error,
    output logic [7:0]    err_count,
    sata_phy_align_scheduler_if.slave link
);

    localparam int unsigned PW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam int unsigned WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned EW = $clog2(ERR_WINDOW + 1);
    localparam int unsigned SW = EW + 1;

    localparam logic [1:0] ST_NOT_READY  = 2'd0;
    localparam logic [1:0] ST_SEND_ALIGN = 2'd1;
    localparam logic [1:0] ST_READY      = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] burst_cnt;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic [SW-1:0] err_sum_c;
    logic          burst_last_c;
    logic          period_last_c;
    logic          win_wrap_c;
    logic          err_trip_c;
    sata_dword_t   tx_sel_c;

    assign burst_last_c  = (burst_cnt == PW'(ALIGN_BURST - 1));
    assign period_last_c = (period_cnt == PW'(ALIGN_PERIOD - 1));
    assign win_wrap_c    = (win_cnt == WW'(ERR_WINDOW - 1));
    assign err_sum_c     = SW'(win_err) + SW'(phy_error);
    assign err_trip_c    = linkup && (err_sum_c >= SW'(ERR_THRESHOLD));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_NOT_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; losing the link or an error trip overrides the burst schedule
    always_comb begin
        state_nxt = state;
        if (!linkup || err_trip_c) begin
            state_nxt = ST_NOT_READY;
        end else begin
            case (state)
                ST_NOT_READY:  if (!platform_error) state_nxt = ST_SEND_ALIGN;
                ST_SEND_ALIGN: if (burst_last_c)    state_nxt = ST_READY;
                ST_READY:      if (period_last_c)   state_nxt = ST_SEND_ALIGN;
                default:                            state_nxt = ST_NOT_READY;
            endcase
        end
    end

    // TX source selection and link-layer ready
    always_comb begin
        tx_sel_c       = '{data: PRIM_ALIGN, is_k: ALIGN_K};
        link.phy_ready = 1'b0;
        if (state == ST_READY) begin
            link.phy_ready = 1'b1;
        end
        if (!linkup) begin
            tx_sel_c = '{data: oob_tx_dout, is_k: oob_tx_is_k};
        end else if (state == ST_READY) begin
            tx_sel_c = '{data: link.link_tx_dout, is_k: link.link_tx_is_k};
        end
    end

    assign tx_dout = tx_sel_c.data;
    assign tx_is_k = tx_sel_c.is_k;

    // Burst/period counters; READY resumes counting at ALIGN_BURST so start-to-start is ALIGN_PERIOD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt  <= '0;
            period_cnt <= '0;
        end else if (!linkup) begin
            burst_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            case (state)
                ST_SEND_ALIGN: begin
                    if (burst_last_c) begin
                        burst_cnt  <= '0;
                        period_cnt <= PW'(ALIGN_BURST);
                    end else begin
                        burst_cnt <= burst_cnt + PW'(1);
                    end
                end
                ST_READY: begin
                    burst_cnt  <= '0;
                    period_cnt <= period_last_c ? '0 : period_cnt + PW'(1);
                end
                default: begin
                    burst_cnt  <= '0;
                    period_cnt <= '0;
                end
            endcase
        end
    end

    // Error window, sticky platform_error and saturating lifetime error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt        <= '0;
            win_err        <= '0;
            platform_error <= 1'b0;
            err_count      <= '0;
        end else if (!linkup) begin
            win_cnt        <= '0;
            win_err        <= '0;
            platform_error <= 1'b0;
            err_count      <= '0;
        end else begin
            if (win_wrap_c) begin
                win_cnt <= '0;
                win_err <= EW'(phy_error);
            end else begin
                win_cnt <= win_cnt + WW'(1);
                win_err <= win_err + EW'(phy_error);
            end
            if (err_trip_c) begin
                platform_error <= 1'b1;
            end
            if (phy_error && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    sata_rx_align_strip u_rx_strip (
        .clk           (clk),
        .rst           (rst),
        .linkup        (linkup),
        .rx_din        (rx_din),
        .rx_is_k       (rx_is_k),
        .phy_error     (phy_error),
        .rx_dout       (link.rx_dout),
        .rx_is_k_out   (link.rx_is_k_out),
        .rx_valid      (link.rx_valid),
        .rx_align_seen (link.rx_align_seen)
    );

endmodule
